// File: rtl/core_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : core_run_ctrl
// Description : Run sequencer for the 9-bit core. It implements the host
//               req/done handshake, holds the core in reset between programs,
//               and gates core execution (PC advance, RegWrite, MemWrite)
//               through a single enable. It also counts execution cycles and
//               stops runaway programs with a timeout.
//
// Parameters  : D       - program counter width (prog_ctr, pc_at_halt)
//               CW      - cycle counter width
//               RST_CYC - cycles core_rst stays asserted in CLEAR (1..15)
//               TIMEOUT - RUN cycles before a forced stop, 0 = no timeout
//
// Ports       : clk        in   system clock, rising edge
//               reset      in   asynchronous active-low reset
//               req        in   host run request, level, held for the run
//               halt       in   core halt opcode decoded, sampled in RUN
//               prog_ctr   in   current core PC, captured at stop
//               step       in   single-step strobe (optional build only)
//               core_rst   out  synchronous reset to the core
//               core_en    out  core advance enable
//               busy       out  run in progress (CLEAR, RUN, DRAIN)
//               done       out  run complete (DONE)
//               timeout    out  last run ended by timeout
//               cycles     out  RUN cycles of the last/current run, saturating
//               pc_at_halt out  prog_ctr on the cycle the run stopped
//
// Build option: CORE_RUN_CTRL_STEP_EN - adds the `step` input; in RUN the
//               core advances only on the cycle after a rising edge of step.
//
// Revision    : 1.0 - initial release
// ============================================================================

module core_run_ctrl #(
    parameter int D       = 12,
    parameter int CW      = 16,
    parameter int RST_CYC = 2,
    parameter int TIMEOUT = 50000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          halt,
    input  logic [D-1:0]  prog_ctr,
`ifdef CORE_RUN_CTRL_STEP_EN
    input  logic          step,
`endif
    output logic          core_rst,
    output logic          core_en,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [CW-1:0] cycles,
    output logic [D-1:0]  pc_at_halt
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // Last value of the CLEAR counter; CLEAR lasts RST_CYC cycles.
    localparam logic [3:0]    c_RST_LAST = 4'(RST_CYC - 1);
    localparam logic [CW-1:0] c_CYC_MAX  = '1;
    localparam logic [CW-1:0] c_CYC_ONE  = CW'(1);
    localparam bit            c_TO_EN    = (TIMEOUT != 0);
    // Count value on the final allowed RUN cycle. When the timeout is
    // disabled the value is unused, so it is pinned to 0 to keep it legal.
    localparam logic [CW-1:0] c_TO_LAST  = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    // ------------------------------------------------------------------------
    // Registers and next-state wires
    // ------------------------------------------------------------------------
    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_rst_cnt;
    logic [3:0]      w_rst_cnt_nxt;
    logic [CW-1:0]   r_cycles;
    logic [CW-1:0]   w_cycles_nxt;
    logic            r_timeout;
    logic            w_timeout_nxt;
    logic [D-1:0]    r_pc;
    logic [D-1:0]    w_pc_nxt;

    logic            w_adv;       // advance qualifier (always 1 without step)
    logic            w_run_adv;   // core actually advances this cycle
    logic            w_halt_hit;
    logic            w_to_hit;

    // ------------------------------------------------------------------------
    // Advance qualifier
    // ------------------------------------------------------------------------
`ifdef CORE_RUN_CTRL_STEP_EN
    logic r_step_d;
    logic r_step_fire;

    // Registered rising-edge detector: r_step_fire is high for exactly the
    // cycle following a 0->1 transition of step, so core_en stays a pure
    // function of registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_step_d    <= 1'b0;
            r_step_fire <= 1'b0;
        end else begin
            r_step_d    <= step;
            r_step_fire <= step & ~r_step_d;
        end
    end

    assign w_adv = r_step_fire;
`else
    assign w_adv = 1'b1;
`endif

    assign w_run_adv  = (r_state == S_RUN) && w_adv;

    // Halt and timeout are evaluated only on cycles where the core advanced.
    // Halt has priority, so a coincident timeout leaves the flag clear.
    assign w_halt_hit = w_run_adv && halt;
    assign w_to_hit   = c_TO_EN && w_run_adv && !halt && (r_cycles == c_TO_LAST);

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_rst_cnt <= 4'd0;
            r_cycles  <= '0;
            r_timeout <= 1'b0;
            r_pc      <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_rst_cnt <= w_rst_cnt_nxt;
            r_cycles  <= w_cycles_nxt;
            r_timeout <= w_timeout_nxt;
            r_pc      <= w_pc_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_rst_cnt_nxt = r_rst_cnt;
        w_cycles_nxt  = r_cycles;
        w_timeout_nxt = r_timeout;
        w_pc_nxt      = r_pc;

        case (r_state)
            S_IDLE: begin
                if (req) begin
                    // Results of the previous run are discarded only when a
                    // new run actually starts.
                    w_state_nxt   = S_CLEAR;
                    w_rst_cnt_nxt = 4'd0;
                    w_cycles_nxt  = '0;
                    w_timeout_nxt = 1'b0;
                    w_pc_nxt      = '0;
                end
            end

            S_CLEAR: begin
                if (!req) begin
                    w_state_nxt = S_IDLE;
                end else if (r_rst_cnt == c_RST_LAST) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_rst_cnt_nxt = r_rst_cnt + 4'd1;
                end
            end

            S_RUN: begin
                // The cycle on which req drops, halt is seen or the timeout
                // fires was itself an executed cycle, so it is counted.
                if (w_run_adv && (r_cycles != c_CYC_MAX)) begin
                    w_cycles_nxt = r_cycles + c_CYC_ONE;
                end

                if (!req) begin
                    w_state_nxt = S_IDLE;
                end else if (w_halt_hit) begin
                    w_state_nxt = S_DRAIN;
                    w_pc_nxt    = prog_ctr;
                end else if (w_to_hit) begin
                    w_state_nxt   = S_DRAIN;
                    w_timeout_nxt = 1'b1;
                    w_pc_nxt      = prog_ctr;
                end
            end

            // One frozen cycle lets the core's last registered write land
            // before the host is told the run is over.
            S_DRAIN: begin
                w_state_nxt = req ? S_DONE : S_IDLE;
            end

            // Held until the host drops req; a high req never re-launches.
            S_DONE: begin
                if (!req) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs, decoded from registered state only
    // ------------------------------------------------------------------------
    assign core_rst   = (r_state == S_IDLE) || (r_state == S_CLEAR);
    assign core_en    = w_run_adv;
    assign busy       = (r_state == S_CLEAR) || (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done       = (r_state == S_DONE);
    assign timeout    = r_timeout;
    assign cycles     = r_cycles;
    assign pc_at_halt = r_pc;

endmodule

`default_nettype wire

// File: tb/tb_core_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_run_ctrl
// Description : Self-checking bench for core_run_ctrl. Run results are pushed
//               into a scoreboard when each run is launched and popped when
//               the DUT raises done. A second instance with a 4-bit counter
//               and no timeout exercises counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_core_run_ctrl;

    localparam int D       = 12;
    localparam int CW      = 16;
    localparam int RST_CYC = 2;
    localparam int TIMEOUT = 20;
    localparam int S_CW    = 4;

`ifdef CORE_RUN_CTRL_STEP_EN
    localparam logic c_EN_RUN = 1'b0;   // no step edge -> no advance
`else
    localparam logic c_EN_RUN = 1'b1;
`endif

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic          clk = 1'b0;
    logic          reset;

    logic          req;
    logic          halt;
    logic [D-1:0]  prog_ctr;
    logic          core_rst, core_en, busy, done, timeout;
    logic [CW-1:0] cycles;
    logic [D-1:0]  pc_at_halt;

    logic            s_req;
    logic            s_halt;
    logic [D-1:0]    s_pc;
    logic            s_core_rst, s_core_en, s_busy, s_done, s_timeout;
    logic [S_CW-1:0] s_cycles;
    logic [D-1:0]    s_pc_at_halt;

`ifdef CORE_RUN_CTRL_STEP_EN
    logic step;
    logic s_step;
`endif

    typedef struct {
        logic [CW-1:0] cyc;
        logic [D-1:0]  pc;
        logic          to;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // DUTs
    // ------------------------------------------------------------------------
    core_run_ctrl #(
        .D(D), .CW(CW), .RST_CYC(RST_CYC), .TIMEOUT(TIMEOUT)
    ) u_dut (
`ifdef CORE_RUN_CTRL_STEP_EN
        .step       (step),
`endif
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .halt       (halt),
        .prog_ctr   (prog_ctr),
        .core_rst   (core_rst),
        .core_en    (core_en),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .cycles     (cycles),
        .pc_at_halt (pc_at_halt)
    );

    core_run_ctrl #(
        .D(D), .CW(S_CW), .RST_CYC(RST_CYC), .TIMEOUT(0)
    ) u_sat (
`ifdef CORE_RUN_CTRL_STEP_EN
        .step       (s_step),
`endif
        .clk        (clk),
        .reset      (reset),
        .req        (s_req),
        .halt       (s_halt),
        .prog_ctr   (s_pc),
        .core_rst   (s_core_rst),
        .core_en    (s_core_en),
        .busy       (s_busy),
        .done       (s_done),
        .timeout    (s_timeout),
        .cycles     (s_cycles),
        .pc_at_halt (s_pc_at_halt)
    );

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------------
    // Reset behaviour, including an asynchronous reset in the middle of RUN
    // ------------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b0;
        req   = 1'b1;
        repeat (3) tick();
        checks++;
        if ({core_rst, core_en, busy, done, timeout} !== 5'b10000 || cycles !== '0 || pc_at_halt !== '0) begin
            errors++;
            $display("FAIL reset_state: rst/en/busy/done/to=%b cycles=%0d pc=%h want 10000 0 000",
                     {core_rst, core_en, busy, done, timeout}, cycles, pc_at_halt);
        end

        reset = 1'b1;
        repeat (RST_CYC) tick();
        checks++;
        if ({core_rst, core_en, busy, done} !== 4'b1010) begin
            errors++;
            $display("FAIL reset_clear: rst/en/busy/done=%b want 1010", {core_rst, core_en, busy, done});
        end

        tick();
        checks++;
        if ({core_rst, core_en, busy, done} !== {1'b0, c_EN_RUN, 2'b10}) begin
            errors++;
            $display("FAIL reset_first_run: rst/en/busy/done=%b want %b",
                     {core_rst, core_en, busy, done}, {1'b0, c_EN_RUN, 2'b10});
        end

        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if ({core_rst, core_en, busy, done, timeout} !== 5'b10000 || cycles !== '0) begin
            errors++;
            $display("FAIL reset_async_mid_run: rst/en/busy/done/to=%b cycles=%0d want 10000 0",
                     {core_rst, core_en, busy, done, timeout}, cycles);
        end
        req = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    // ------------------------------------------------------------------------
    // One complete run on u_dut. halt_at = RUN cycle index carrying halt,
    // 0 = never. Expected results go to the scoreboard at launch.
    // ------------------------------------------------------------------------
    task automatic do_run(input string name, input int halt_at, input logic [D-1:0] pc,
                          input logic [CW-1:0] exp_cyc, input logic exp_to);
        exp_t e;
        bit   got;
        int   k;
        int   i_drop;
        int   i_done;

        e.cyc = exp_cyc;
        e.pc  = pc;
        e.to  = exp_to;
        sb_q.push_back(e);

        prog_ctr = pc;
        req      = 1'b1;
        tick();
        checks++;
        if ({core_rst, core_en, busy, done} !== 4'b1010 || cycles !== '0 || pc_at_halt !== '0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL %s_start: rst/en/busy/done=%b cycles=%0d pc=%h to=%b want 1010 0 000 0",
                     name, {core_rst, core_en, busy, done}, cycles, pc_at_halt, timeout);
        end

        repeat (RST_CYC - 1) tick();
        tick();
        checks++;
        if ({core_rst, core_en} !== 2'b01) begin
            errors++;
            $display("FAIL %s_run_entry: rst/en=%b want 01", name, {core_rst, core_en});
        end

        got    = 0;
        k      = 0;
        i_drop = -1;
        i_done = -1;
        for (int i = 0; i < 200 && !got; i++) begin
            k++;
            halt = (k == halt_at);
            tick();
            halt = 1'b0;
            if (!core_en && i_drop < 0) i_drop = i;
            if (done) begin
                got    = 1;
                i_done = i;
            end
        end

        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s_done_wait: done=0 after 200 cycles want 1", name);
            void'(sb_q.pop_front());
        end else begin
            e = sb_q.pop_front();
            if (cycles !== e.cyc || pc_at_halt !== e.pc || timeout !== e.to || busy !== 1'b0) begin
                errors++;
                $display("FAIL %s_result: cycles=%0d pc=%h to=%b busy=%b want %0d %h %b 0",
                         name, cycles, pc_at_halt, timeout, busy, e.cyc, e.pc, e.to);
            end
            checks++;
            if (i_done !== i_drop + 1) begin
                errors++;
                $display("FAIL %s_drain_len: done at %0d en drop at %0d want one cycle apart",
                         name, i_done, i_drop);
            end
        end

        repeat (3) tick();
        checks++;
        if ({done, busy, core_rst, core_en} !== 4'b1000) begin
            errors++;
            $display("FAIL %s_hold_done: done/busy/rst/en=%b want 1000", name, {done, busy, core_rst, core_en});
        end

        req = 1'b0;
        tick();
        checks++;
        if ({done, core_rst} !== 2'b01) begin
            errors++;
            $display("FAIL %s_release: done/rst=%b want 01", name, {done, core_rst});
        end
    endtask

    task automatic test_normal_halt();
        do_run("halt10", 10, 12'h03A, 16'd10, 1'b0);
        do_run("halt1", 1, 12'h001, 16'd1, 1'b0);
    endtask

    task automatic test_timeout();
        do_run("halt19", 19, 12'h7FF, 16'd19, 1'b0);
        do_run("halt_vs_to", 20, 12'h123, 16'd20, 1'b0);
        do_run("timeout", 0, 12'h155, 16'd20, 1'b1);
    endtask

    // Back-to-back: req is low for exactly one cycle between runs.
    task automatic test_back_to_back();
        do_run("b2b_a", 7, 12'hABC, 16'd7, 1'b0);
        do_run("b2b_b", 3, 12'h00F, 16'd3, 1'b0);
    endtask

    // ------------------------------------------------------------------------
    // Abort in RUN (after a timeout run so the cleared flag is visible) and
    // in CLEAR
    // ------------------------------------------------------------------------
    task automatic test_abort();
        prog_ctr = 12'h0F0;
        req      = 1'b1;
        repeat (RST_CYC + 1) tick();
        repeat (4) tick();
        req = 1'b0;
        tick();
        checks++;
        if ({core_rst, core_en, busy, done} !== 4'b1000 || cycles !== 16'd5) begin
            errors++;
            $display("FAIL abort_run: rst/en/busy/done=%b cycles=%0d want 1000 5",
                     {core_rst, core_en, busy, done}, cycles);
        end
        repeat (3) tick();
        checks++;
        if (done !== 1'b0 || cycles !== 16'd5 || pc_at_halt !== '0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL abort_hold: done=%b cycles=%0d pc=%h to=%b want 0 5 000 0",
                     done, cycles, pc_at_halt, timeout);
        end

        req = 1'b1;
        tick();
        req = 1'b0;
        tick();
        checks++;
        if ({core_rst, busy, done} !== 3'b100) begin
            errors++;
            $display("FAIL abort_clear: rst/busy/done=%b want 100", {core_rst, busy, done});
        end
        tick();
    endtask

    // ------------------------------------------------------------------------
    // Saturation of a 4-bit counter with timeout disabled, then a restart
    // ------------------------------------------------------------------------
    task automatic test_saturation();
        s_pc  = 12'h2C4;
        s_req = 1'b1;
        repeat (RST_CYC + 1) tick();
        repeat (20) tick();
        checks++;
        if (s_cycles !== 4'hF || s_busy !== 1'b1 || s_core_en !== 1'b1) begin
            errors++;
            $display("FAIL sat_count: cycles=%h busy=%b en=%b want f 1 1", s_cycles, s_busy, s_core_en);
        end

        s_halt = 1'b1;
        tick();
        s_halt = 1'b0;
        tick();
        checks++;
        if (s_done !== 1'b1 || s_cycles !== 4'hF || s_timeout !== 1'b0 || s_pc_at_halt !== 12'h2C4) begin
            errors++;
            $display("FAIL sat_done: done=%b cycles=%h to=%b pc=%h want 1 f 0 2c4",
                     s_done, s_cycles, s_timeout, s_pc_at_halt);
        end

        s_req = 1'b0;
        tick();
        s_req = 1'b1;
        tick();
        checks++;
        if ({s_busy, s_core_rst, s_done} !== 3'b110 || s_cycles !== 4'h0) begin
            errors++;
            $display("FAIL sat_restart: busy/rst/done=%b cycles=%h want 110 0",
                     {s_busy, s_core_rst, s_done}, s_cycles);
        end
        s_req = 1'b0;
        tick();
    endtask

`ifdef CORE_RUN_CTRL_STEP_EN
    // ------------------------------------------------------------------------
    // Single-step: three step pulses, halt held between the 2nd and 3rd
    // ------------------------------------------------------------------------
    task automatic test_step();
        exp_t e;
        int   en_cnt;

        e.cyc = 16'd3;
        e.pc  = 12'h0AB;
        e.to  = 1'b0;
        sb_q.push_back(e);

        step     = 1'b0;
        prog_ctr = 12'h0AB;
        req      = 1'b1;
        repeat (RST_CYC + 1) tick();
        checks++;
        if ({busy, core_en} !== 2'b10) begin
            errors++;
            $display("FAIL step_idle_run: busy/en=%b want 10", {busy, core_en});
        end

        en_cnt = 0;
        for (int p = 0; p < 2; p++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            if (core_en) en_cnt++;
            repeat (4) begin
                tick();
                if (core_en) en_cnt++;
            end
        end

        halt = 1'b1;
        repeat (4) begin
            tick();
            if (core_en) en_cnt++;
        end
        checks++;
        if ({busy, done} !== 2'b10 || cycles !== 16'd2) begin
            errors++;
            $display("FAIL step_halt_ignored: busy/done=%b cycles=%0d want 10 2", {busy, done}, cycles);
        end

        step = 1'b1;
        tick();
        step = 1'b0;
        if (core_en) en_cnt++;
        tick();
        halt = 1'b0;
        if (core_en) en_cnt++;
        tick();
        if (core_en) en_cnt++;

        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL step_done: done=%b want 1", done);
            void'(sb_q.pop_front());
        end else begin
            e = sb_q.pop_front();
            if (cycles !== e.cyc || pc_at_halt !== e.pc || timeout !== e.to) begin
                errors++;
                $display("FAIL step_result: cycles=%0d pc=%h to=%b want %0d %h %b",
                         cycles, pc_at_halt, timeout, e.cyc, e.pc, e.to);
            end
        end
        checks++;
        if (en_cnt !== 3) begin
            errors++;
            $display("FAIL step_en_count: core_en cycles=%0d want 3", en_cnt);
        end
        req = 1'b0;
        tick();
    endtask
`endif

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------
    initial begin
        reset    = 1'b0;
        req      = 1'b0;
        halt     = 1'b0;
        prog_ctr = '0;
        s_req    = 1'b0;
        s_halt   = 1'b0;
        s_pc     = '0;
`ifdef CORE_RUN_CTRL_STEP_EN
        step     = 1'b0;
        s_step   = 1'b0;
`endif
        #2;
        test_reset();
`ifdef CORE_RUN_CTRL_STEP_EN
        test_step();
`else
        test_normal_halt();
        test_timeout();
        test_abort();
        test_back_to_back();
        test_saturation();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire
